// File: rtl/data_sram_slave_if.sv
// Data-port bus between the CPU memory stage (master) and an SRAM-like responder (slave).
interface data_sram_slave_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] daddr;
  logic [31:0] din;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, daddr, din,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, daddr, din,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sram_slave.sv
// Single-outstanding SRAM responder with byte/half/word writes and fixed response latency.
// Optional DSRAM_STALL_EN: LFSR-driven pseudo-random accept stalls for stress testing.
module data_sram_slave #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  data_sram_slave_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [DEPTH];
  logic              accept;
  logic              gate_ok;
  logic [ADDR_W-1:0] widx;
  logic [3:0]        wmask;
  logic              unused_addr;

  // Misaligned halfword/word accesses yield an empty mask and so write nothing.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      2'd0:    m = 4'b0001 << off;
      2'd1:    m = (off == 2'd0) ? 4'b0011 : ((off == 2'd2) ? 4'b1100 : 4'b0000);
      default: m = (off == 2'd0) ? 4'b1111 : 4'b0000;
    endcase
    return m;
  endfunction

  assign widx        = bus.daddr[ADDR_W+1:2];
  assign unused_addr = ^bus.daddr[31:ADDR_W+2];
  assign wmask       = lane_mask(bus.data_size, bus.daddr[1:0]);

`ifdef DSRAM_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign gate_ok = ~lfsr_q[0];

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) lfsr_q <= 8'hA5;
    else         lfsr_q <= lfsr_d;
  end
`else
  assign gate_ok = 1'b1;
`endif

  assign accept = bus.data_req & ((state_q == IDLE) | (state_q == RESP)) & ~cpu_rst & gate_ok;
  assign bus.data_addr_ok = accept;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'd0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? RESP : WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = rdata_q;
        // A new accept in the response cycle restarts the latency count.
        if (accept) begin
          state_d = (LATENCY == 1) ? RESP : WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (accept && bus.data_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[k]) mem[widx][8*k +: 8] <= bus.din[8*k +: 8];
      end
    end
  end

  // Read data is captured at the accept edge; writes respond with zero.
  always_ff @(posedge cpu_clk_50M) begin
    if (accept) rdata_q <= bus.data_wr ? 32'd0 : mem[widx];
  end

endmodule

// File: doc/data_sram_slave.md
# data_sram_slave

SRAM-like data-port responder: the slave end of the `data_req`/`data_addr_ok`/`data_data_ok` interface driven by the CPU memory-access stage. It accepts one request at a time, performs a byte-, halfword- or word-granular write or a word read on an internal synchronous RAM, and signals completion after a fixed, parameterised latency. It sits directly on the CPU data port in simulation-only and FPGA-standalone builds, in place of the AXI bridge. It also serves as the bench responder for memory-stage verification.

## Interface
- `ADDR_W`, 12: word-index width; RAM depth is 2^ADDR_W 32-bit words.
- `LATENCY`, 1: cycles from the address-accept cycle to the `data_data_ok` cycle; legal range 1..15.
- `cpu_clk_50M` in 1: sole clock, rising edge.
- `cpu_rst` in 1: synchronous, active-high reset.
- `data_req` in 1: request valid; held by the requester until `data_addr_ok`.
- `data_wr` in 1: 1 = write, 0 = read.
- `data_size` in 2: 0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- `daddr` in 32: physical byte address.
- `din` in 32: write data, lane-replicated by the requester.
- `data_addr_ok` out 1: request accepted this cycle (handshake = `data_req & data_addr_ok`).
- `data_data_ok` out 1: one-cycle completion pulse.
- `data_rdata` out 32: read word, valid while `data_data_ok` is high for a read.

## Operation
- Word index = `daddr[ADDR_W+1:2]`. Bits above are ignored, so the address space aliases modulo 2^(ADDR_W+2) bytes.
- Byte lanes are little-endian: `daddr[1:0]`=k selects bits [8k+7:8k].
  - Byte: mask = 1<<k.
  - Halfword: mask 0011 for k=0, 1100 for k=2.
  - Word: mask 1111.
- Misaligned access gets mask 0000 and performs no write. Misaligned cases are halfword with `daddr[0]`=1, or word with `daddr[1:0]`≠0. The request is still accepted and completed normally.
- Each write lane takes `din[8k+7:8k]`.
- Writes commit to RAM at the accept edge.
- Reads sample the RAM at the accept edge and see any write committed at an earlier edge. The result is held in a register and driven on `data_rdata` in RESP.
- Write responses drive `data_rdata` = 0.
- State machine:
  - IDLE: on accept, go to RESP if LATENCY==1; otherwise go to WAIT with `cnt`=LATENCY-2.
  - WAIT: if `cnt`==0, go to RESP; else decrement `cnt`.
  - RESP: `data_data_ok`=1. On accept in this same cycle, reload as from IDLE; otherwise go to IDLE.
- `data_addr_ok` = `data_req` & (IDLE | RESP) & ~`cpu_rst`, combinational. It is never asserted in WAIT, so at most one transaction is outstanding.
- RAM contents are not reset.

## Timing
- Reset values:
  - state IDLE, `cnt`=0.
  - `data_data_ok`=0, `data_rdata`=0.
  - `data_addr_ok`=0 while `cpu_rst` is high.
- Latency: accept in cycle T gives `data_data_ok` in cycle T+LATENCY, exactly one cycle wide.
- Back-to-back: with LATENCY=1 and `data_req` held high, the block sustains one accept and one response per cycle. Response of request n and accept of request n+1 coincide.
- Reset in WAIT or RESP aborts the pending response; no `data_data_ok` is produced. A write accepted before the reset edge stays committed.
- `data_req` dropping while the block is not ready: nothing is accepted and there is no side effect.

## Configuration
- `DSRAM_STALL_EN` defined:
  - An 8-bit Fibonacci LFSR with taps 8,6,5,4 and reset seed 8'hA5 advances every cycle.
  - `data_addr_ok` is additionally gated by ~`lfsr[0]`, inserting deterministic pseudo-random accept stalls for stress testing.
  - Latency from accept to `data_data_ok` is unchanged.
- `DSRAM_STALL_EN` undefined: no LFSR; `data_addr_ok` is exactly as in Operation.

## Test plan
- LATENCY=1, 16-bit addresses:
  - Word write 32'hDEADBEEF @0x0010, then word read @0x0010.
  - Expect `data_data_ok` at T+1 for each request and `data_rdata`=32'hDEADBEEF.
- Byte write `din`=32'h5A5A5A5A @0x0013 over 0x0, then read @0x0010:
  - Expect 32'h5A000000.
  - Then halfword write `din`=32'h12341234 @0x0010 and read: expect 32'h5A001234.
- LATENCY=3:
  - Read accepted in cycle 10 → `data_addr_ok` low in cycles 11-12, `data_data_ok` only in cycle 13.
- LATENCY=1, `data_req` held for 4 reads @0x0,0x4,0x8,0xC:
  - Expect 4 consecutive `data_data_ok` cycles with the matching words in order.
- Misaligned and reset cases:
  - Word write @0x0012 → completes with no RAM change.
  - LATENCY=4, assert `cpu_rst` one cycle after a read accept → no `data_data_ok`, and all outputs are 0 in the next cycle.
- ADDR_W=4:
  - Write @0x0040, then read @0x0000 → the same word (aliasing).
